unified_mem_arbiter: RTL

Sequencing controller and arbiter that shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store). It grants one access at a time and drives the memory handshake. It returns read data with a one-cycle ready pulse and generates the stall requests the pipeline hazard logic ORs into its global stall. Data accesses win by default; a starvation counter guarantees fetch progress, and a branch flush cancels an in-flight fetch.

---
 rtl/unified_mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter and sequencer sharing one single-ported, variable-latency memory
// between instruction fetch and load/store; data wins unless fetch is starved.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             drop;
  logic             if_ready_q;
  logic             if_cand;
  logic             d_cand;
  logic             starved;
  logic             grant_d;
  logic             grant_f;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  // A late flush still cancels a fetch whose ready pulse is already on the wire.
  assign if_ready  = if_ready_q & ~flush;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  // Requesters completing this cycle sit out so a held request is not reissued.
  always_comb begin
    if_cand = if_req & ~if_ready_q & ~flush;
    d_cand  = d_req & ~d_ready;
    starved = (starve_cnt == CNT_W'(STARVE_MAX));
    grant_d = (state == IDLE) & d_cand & (~if_cand | ~starved);
    grant_f = (state == IDLE) & if_cand & ~grant_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready_q <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
      drop       <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr[ADDR_W-1:2];
            mem_wdata <= d_wdata;
          end else if (grant_f) begin
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr[ADDR_W-1:2];
            mem_wdata <= '0;
          end
          if (grant_f || !if_req) begin
            starve_cnt <= '0;
          end else if (grant_d && !flush && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        FETCH: begin
          // A flush landing on the ack cycle cancels this fetch as well.
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            drop    <= 1'b0;
            if (!(drop || flush)) begin
              if_ready_q <= 1'b1;
              if_rdata   <= mem_rdata;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
